// File: rtl/exp2_pwl_eval.sv
// Three-stage, multi-lane piecewise-linear evaluator of 2^f (f in [0,1), Q26): y = k*f + b.
// Optional range check on the integer bits of x is enabled by defining EXP2_PWL_RANGE_CHK_EN.
module exp2_pwl_eval #(
    parameter int Q            = 26,
    parameter int W            = 32,
    parameter int NUM_SEGMENTS = 8,
    parameter int NUM_LANES    = 32,
    localparam int SEG_W       = $clog2(NUM_SEGMENTS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [W-1:0]  x_in              [NUM_LANES],
    output logic [SEG_W-1:0]     lut_segment_index [NUM_LANES],
    input  logic signed [W-1:0]  lut_k_coeff       [NUM_LANES],
    input  logic signed [W-1:0]  lut_b_intercept   [NUM_LANES],
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [W-1:0]  y_out             [NUM_LANES],
    output logic                 out_err           [NUM_LANES]
);

    localparam logic signed [2*W-1:0] RND = (2*W)'(1) << (Q-1);

    logic v1_reg, v2_reg, v3_reg;
    logic stall;
    logic accept;

    // One global stall freezes every stage, so bubbles stay where they are.
    assign stall     = v3_reg & ~out_ready;
    assign in_ready  = ~stall;
    assign accept    = in_valid & ~stall;
    assign out_valid = v3_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_reg <= 1'b0;
            v2_reg <= 1'b0;
            v3_reg <= 1'b0;
        end else if (!stall) begin
            v1_reg <= in_valid;
            v2_reg <= v1_reg;
            v3_reg <= v2_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic                   flag;
            logic [SEG_W-1:0]       seg_next;
            logic signed [W-1:0]    frac;
            logic signed [2*W-1:0]  prod_next;
            logic signed [2*W-1:0]  rounded;
            logic signed [W-1:0]    y_sum;

            logic [SEG_W-1:0]       seg1_reg;
            logic signed [W-1:0]    x1_reg;
            logic                   err1_reg, err2_reg, err3_reg;
            logic signed [2*W-1:0]  prod2_reg;
            logic signed [W-1:0]    b2_reg;
            logic signed [W-1:0]    y3_reg;

`ifdef EXP2_PWL_RANGE_CHK_EN
            assign flag = (x_in[gi][W-1:Q] != '0);
`else
            assign flag = 1'b0;
`endif
            // Only the fractional bits feed the datapath; integer bits are either flagged or ignored.
            assign seg_next  = flag ? '0 : x_in[gi][Q-1 -: SEG_W];
            assign frac      = {{(W-Q){1'b0}}, x_in[gi][Q-1:0]};
            assign prod_next = $signed({{W{lut_k_coeff[gi][W-1]}}, lut_k_coeff[gi]})
                             * $signed({{W{x1_reg[W-1]}}, x1_reg});
            assign rounded   = prod2_reg + RND;
            assign y_sum     = b2_reg + W'(rounded >>> Q);

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    seg1_reg <= '0;
                    err1_reg <= 1'b0;
                    err2_reg <= 1'b0;
                    err3_reg <= 1'b0;
                    y3_reg   <= '0;
                end else if (!stall) begin
                    if (accept) begin
                        seg1_reg <= seg_next;
                        err1_reg <= flag;
                    end
                    if (v1_reg) begin
                        err2_reg <= err1_reg;
                    end
                    if (v2_reg) begin
                        err3_reg <= err2_reg;
                        y3_reg   <= err2_reg ? '0 : y_sum;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (accept) begin
                    x1_reg <= frac;
                end
                if (!stall && v1_reg) begin
                    prod2_reg <= prod_next;
                    b2_reg    <= lut_b_intercept[gi];
                end
            end

            assign lut_segment_index[gi] = seg1_reg;
            assign y_out[gi]             = y3_reg;
`ifdef EXP2_PWL_RANGE_CHK_EN
            assign out_err[gi]           = err3_reg;
`else
            assign out_err[gi]           = 1'b0;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_exp2_pwl_eval.sv
// Directed bench for exp2_pwl_eval with a behavioural 8-entry chord LUT (2^f, Q26).
module tb_exp2_pwl_eval;

    localparam int L = 32;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [31:0] x_in    [L];
    logic [2:0]         lut_seg [L];
    logic signed [31:0] lut_k   [L];
    logic signed [31:0] lut_b   [L];
    logic               out_valid;
    logic               out_ready;
    logic signed [31:0] y_out   [L];
    logic               out_err [L];

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    exp2_pwl_eval dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .x_in              (x_in),
        .lut_segment_index (lut_seg),
        .lut_k_coeff       (lut_k),
        .lut_b_intercept   (lut_b),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .y_out             (y_out),
        .out_err           (out_err)
    );

    // Chord coefficients of 2^f over [i/8,(i+1)/8); b0 = 1.0, k4/b4 hit sqrt(2) at f=0.5, k7+b7 = 2 - 1 lsb.
    function automatic logic signed [31:0] k_of(input logic [2:0] s);
        case (s)
            3'd0: return 32'sd48590969;
            3'd1: return 32'sd52988837;
            3'd2: return 32'sd57784758;
            3'd3: return 32'sd63014687;
            3'd4: return 32'sd68718008;
            3'd5: return 32'sd74937517;
            3'd6: return 32'sd81719965;
            default: return 32'sd89116230;
        endcase
    endfunction

    function automatic logic signed [31:0] b_of(input logic [2:0] s);
        case (s)
            3'd0: return 32'sd67108864;
            3'd1: return 32'sd66559129;
            3'd2: return 32'sd65360148;
            3'd3: return 32'sd63398923;
            3'd4: return 32'sd60547261;
            3'd5: return 32'sd56660068;
            3'd6: return 32'sd51573230;
            default: return 32'sd45101497;
        endcase
    endfunction

    always_comb begin
        for (int i = 0; i < L; i++) begin
            lut_k[i] = k_of(lut_seg[i]);
            lut_b[i] = b_of(lut_seg[i]);
        end
    end

    // Reference: y = b + round_half_up(k*f / 2^26), f = low 26 bits of x.
    function automatic logic signed [31:0] model_y(input logic [31:0] x);
        logic [2:0] s;
        longint     p;
        s = x[25:23];
        p = longint'(k_of(s)) * longint'({6'b0, x[25:0]});
        p = p + (64'sd1 <<< 25);
        return b_of(s) + 32'(p >>> 26);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_beat();
        in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
    endtask

    initial begin
        int               in_idx;
        int               out_idx;
        int               cyc;
        bit               have_held;
        logic signed [31:0] held;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < L; i++) x_in[i] = '0;

        // Reset
        tick(2);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_y0", y_out[0], 32'h0);
        check("rst_seg0", lut_seg[0], 3'd0);
        rst_n = 1'b1;
        tick(1);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid2", out_valid, 1'b0);
        $display("[TB] reset done");

        // f = 0 on every lane
        push_beat();
        check("f0_seg", lut_seg[0], 3'd0);
        check("f0_lat1", out_valid, 1'b0);
        tick(1);
        check("f0_lat2", out_valid, 1'b0);
        tick(1);
        check("f0_valid", out_valid, 1'b1);
        for (int i = 0; i < L; i++) check("f0_y", y_out[i], 32'h04000000);
        check("f0_err", out_err[0], 1'b0);
        $display("[TB] beat f=0 lane0 y=%h", y_out[0]);
        tick(1);
        check("f0_bubble", out_valid, 1'b0);

        // seg4 (f=0.5) on even lanes, seg7 (f just below 1) on odd lanes
        for (int i = 0; i < L; i++) x_in[i] = (i % 2 == 0) ? 32'h02000000 : 32'h03FFFFFF;
        push_beat();
        check("seg4_idx", lut_seg[0], 3'd4);
        check("seg7_idx", lut_seg[1], 3'd7);
        tick(2);
        check("seg_valid", out_valid, 1'b1);
        check("seg4_y", y_out[0], 32'h05A82799);
        check("seg7_y", y_out[1], 32'h07FFFFFE);
        check("seg4_y30", y_out[30], 32'h05A82799);
        check("seg7_y31", y_out[31], 32'h07FFFFFE);
        $display("[TB] beat seg4 y=%h seg7 y=%h", y_out[0], y_out[1]);
        tick(1);

        // Back-pressure: 10 beats, out_ready low for 5 cycles mid-stream
        in_idx = 0; out_idx = 0; cyc = 0; have_held = 1'b0; held = '0;
        while (out_idx < 10 && cyc < 200) begin
            out_ready = !(cyc >= 4 && cyc < 9);
            in_valid  = (in_idx < 10);
            for (int i = 0; i < L; i++) x_in[i] = i * 32'h00200000 + in_idx;
            #1;
            if (!out_ready && out_valid) begin
                check("bp_in_ready", in_ready, 1'b0);
                check("bp_hold_y", y_out[7], model_y(7 * 32'h00200000 + out_idx));
                if (!have_held) begin
                    held = y_out[3];
                    have_held = 1'b1;
                end else begin
                    check("bp_stable", y_out[3], held);
                end
            end
            if (out_valid && out_ready) begin
                for (int i = 0; i < L; i++) check("bp_y", y_out[i], model_y(i * 32'h00200000 + out_idx));
                $display("[TB] beat %0d out lane31 y=%h", out_idx, y_out[31]);
                out_idx++;
            end
            if (in_valid && in_ready) in_idx++;
            tick(1);
            cyc++;
        end
        check("bp_count", out_idx, 10);
        check("bp_held_seen", have_held, 1'b1);
        in_valid = 1'b0; out_ready = 1'b1;
        tick(3);
        check("bp_no_extra", out_valid, 1'b0);

        // Reset with three beats in flight
        for (int i = 0; i < L; i++) x_in[i] = 32'h01C00000;
        in_valid = 1'b1;
        tick(3);
        in_valid = 1'b0;
        check("mid_full", out_valid, 1'b1);
        rst_n = 1'b0;
        tick(1);
        check("mid_out_valid", out_valid, 1'b0);
        check("mid_y", y_out[0], 32'h0);
        check("mid_seg", lut_seg[0], 3'd0);
        check("mid_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick(1);
            check("mid_no_stale", out_valid, 1'b0);
        end
        $display("[TB] mid-stream reset done");

        // Integer bits set on lanes 0 and 1
        for (int i = 0; i < L; i++) x_in[i] = 32'h01000000;
        x_in[0] = 32'h04000000;
        x_in[1] = 32'hFC000000;
        push_beat();
        check("rc_seg0", lut_seg[0], 3'd0);
        check("rc_seg1", lut_seg[1], 3'd0);
        check("rc_seg2", lut_seg[2], 3'd2);
        tick(2);
        check("rc_valid", out_valid, 1'b1);
`ifdef EXP2_PWL_RANGE_CHK_EN
        check("rc_y0", y_out[0], 32'h0);
        check("rc_y1", y_out[1], 32'h0);
        check("rc_err0", out_err[0], 1'b1);
        check("rc_err1", out_err[1], 1'b1);
`else
        check("rc_y0", y_out[0], 32'h04000000);
        check("rc_y1", y_out[1], 32'h04000000);
        check("rc_err0", out_err[0], 1'b0);
        check("rc_err1", out_err[1], 1'b0);
`endif
        check("rc_y2", y_out[2], 32'sd79806338);
        check("rc_y31", y_out[31], model_y(32'h01000000));
        check("rc_err2", out_err[2], 1'b0);
        $display("[TB] beat range lane0 y=%h err=%0d", y_out[0], out_err[0]);
        tick(1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
